// File: rtl/posit_encoder.sv
// posit_encoder: packs an unpacked posit into an N-bit word over a 2-stage pipeline.
// Define POSIT_ENC_STATUS_EN to add the out_inexact/out_sat status outputs.
module posit_encoder #(
  parameter int N       = 16,
  parameter int ES      = 2,
  parameter int SCALE_W = 8,
  parameter int FW      = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic               in_zero,
  input  logic               in_nar,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [FW-1:0]      in_frac,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef POSIT_ENC_STATUS_EN
  output logic               out_inexact,
  output logic               out_sat,
`endif
  output logic [N-1:0]       out_posit
);

  localparam int KW = SCALE_W - ES;
  localparam int BW = N + ES + FW + 2;

  logic                 r_v1;
  logic                 r_sign;
  logic                 r_zero;
  logic                 r_nar;
  logic signed [KW-1:0] r_k;
  logic [ES-1:0]        r_e;
  logic [FW-1:0]        r_frac;
  logic                 r_sticky;
  logic                 r_v2;
  logic [N-1:0]         r_posit;

  logic                 w_stall;
  logic signed [31:0]   w_k;
  logic signed [31:0]   w_sh;
  logic                 w_neg;
  logic [BW-1:0]        w_base;
  logic [BW-1:0]        w_lsr;
  logic [BW-1:0]        w_asr;
  logic [BW-1:0]        w_body;
  logic [N-2:0]         w_mag;
  logic [N-2:0]         w_magf;
  logic                 w_guard;
  logic                 w_st;
  logic                 w_up;
  logic                 w_sat;
  logic                 w_inexact;
  logic [N-1:0]         w_word;

  assign w_stall   = r_v2 & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_v2;
  assign out_posit = r_posit;

  always_comb begin
    w_k     = 32'(r_k);
    w_neg   = w_k < 0;
    w_sh    = w_neg ? (-w_k - 32'sd1) : w_k;
    // Marker pair: shifting it right grows the regime run
    w_base  = {w_neg ? 2'b01 : 2'b10, r_e, r_frac, {N{1'b0}}};
    w_lsr   = w_base >> w_sh;
    w_asr   = $signed(w_base) >>> w_sh;
    w_body  = w_neg ? w_lsr : w_asr;
    w_mag   = w_body[BW-1 -: N-1];
    w_guard = w_body[BW-N];
    w_st    = (|w_body[BW-N-1:0]) | r_sticky;
    w_up    = w_guard & (w_st | w_mag[0]);
    w_sat   = 1'b0;
    w_magf  = w_mag + (N-1)'(w_up);
    if (w_k >= N - 2) begin
      w_sat  = 1'b1;
      w_magf = {(N-1){1'b1}};
    end else if (w_k <= 2 - N) begin
      w_sat  = 1'b1;
      w_magf = (N-1)'(1);
    end
    w_inexact = (w_guard | w_st) & ~w_sat;
    w_word    = {1'b0, w_magf};
    if (r_sign)
      w_word = -w_word;
    if (r_nar) begin
      w_word    = {1'b1, {(N-1){1'b0}}};
      w_sat     = 1'b0;
      w_inexact = 1'b0;
    end else if (r_zero) begin
      w_word    = '0;
      w_sat     = 1'b0;
      w_inexact = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_nar    <= 1'b0;
      r_k      <= '0;
      r_e      <= '0;
      r_frac   <= '0;
      r_sticky <= 1'b0;
      r_v2     <= 1'b0;
      r_posit  <= '0;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      if (in_valid) begin
        r_sign   <= in_sign;
        r_zero   <= in_zero;
        r_nar    <= in_nar;
        r_k      <= in_scale[SCALE_W-1:ES];
        r_e      <= in_scale[ES-1:0];
        r_frac   <= in_frac;
        r_sticky <= in_sticky;
      end
      if (r_v1)
        r_posit <= w_word;
    end
  end

`ifdef POSIT_ENC_STATUS_EN
  logic r_inexact;
  logic r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inexact <= 1'b0;
      r_sat     <= 1'b0;
    end else if (!w_stall && r_v1) begin
      r_inexact <= w_inexact;
      r_sat     <= w_sat;
    end
  end

  assign out_inexact = r_inexact;
  assign out_sat     = r_sat;
`else
  logic w_unused;
  assign w_unused = w_inexact;
`endif

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: directed vector table plus stall and reset sequences
// for the posit_encoder pipeline (N=16, ES=2).
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_zero;
  logic        in_nar;
  logic [7:0]  in_scale;
  logic [13:0] in_frac;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_posit;
`ifdef POSIT_ENC_STATUS_EN
  logic        out_inexact;
  logic        out_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  posit_encoder #(.N(16), .ES(2), .SCALE_W(8), .FW(14)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_zero    (in_zero),
    .in_nar     (in_nar),
    .in_scale   (in_scale),
    .in_frac    (in_frac),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef POSIT_ENC_STATUS_EN
    .out_inexact(out_inexact),
    .out_sat    (out_sat),
`endif
    .out_posit  (out_posit)
  );

  typedef struct {
    logic        sign;
    logic        zero;
    logic        nar;
    logic [7:0]  scale;
    logic [13:0] frac;
    logic        sticky;
    logic [15:0] exp;
    logic        sat;
    logic        inx;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign   = v.sign;
    in_zero   = v.zero;
    in_nar    = v.nar;
    in_scale  = v.scale;
    in_frac   = v.frac;
    in_sticky = v.sticky;
  endtask

  function automatic vec_t mkw(input logic [7:0] sc);
    vec_t v;
    v = '{0, 0, 0, sc, 14'h0, 0, 16'h0, 0, 0};
    return v;
  endfunction

  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    drive(tv[i]);
    in_valid = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    chk($sformatf("v%0d_posit", i), 32'(out_posit), 32'(tv[i].exp));
`ifdef POSIT_ENC_STATUS_EN
    chk($sformatf("v%0d_sat", i), 32'(out_sat), 32'(tv[i].sat));
    chk($sformatf("v%0d_inexact", i), 32'(out_inexact), 32'(tv[i].inx));
`endif
  endtask

  logic [7:0]  ws[4];
  logic [15:0] we[4];
  logic [15:0] rx[$];
  logic [15:0] prev;
  logic        prev_stall;
  int          sent;

  initial begin
    tv[0]  = '{0, 0, 0, 8'h00, 14'h0000, 0, 16'h4000, 0, 0};
    tv[1]  = '{1, 0, 0, 8'h00, 14'h0000, 0, 16'hC000, 0, 0};
    tv[2]  = '{0, 0, 0, 8'h04, 14'h0000, 0, 16'h6000, 0, 0};
    tv[3]  = '{0, 0, 0, 8'hFF, 14'h0000, 0, 16'h3800, 0, 0};
    tv[4]  = '{0, 0, 1, 8'h00, 14'h0000, 0, 16'h8000, 0, 0};
    tv[5]  = '{1, 1, 0, 8'h00, 14'h0000, 0, 16'h0000, 0, 0};
    tv[6]  = '{0, 0, 0, 8'h00, 14'b00000000001100, 0, 16'h4002, 0, 1};
    tv[7]  = '{0, 0, 0, 8'h00, 14'b00000000000100, 0, 16'h4000, 0, 1};
    tv[8]  = '{0, 0, 0, 8'h00, 14'b11111111111100, 0, 16'h4800, 0, 1};
    tv[9]  = '{0, 0, 0, 8'd60, 14'h0000, 0, 16'h7FFF, 1, 0};
    tv[10] = '{0, 0, 0, 8'hC4, 14'h0000, 0, 16'h0001, 1, 0};
    tv[11] = '{1, 0, 0, 8'hC4, 14'h0000, 0, 16'hFFFF, 1, 0};
    tv[12] = '{1, 0, 1, 8'h00, 14'h0000, 0, 16'h8000, 0, 0};
    tv[13] = '{0, 0, 0, 8'd52, 14'h0000, 0, 16'h7FFE, 0, 0};
    tv[14] = '{0, 0, 0, 8'd55, 14'h0000, 0, 16'h7FFF, 0, 1};
    tv[15] = '{0, 0, 0, 8'hCC, 14'h0000, 0, 16'h0002, 0, 0};
    tv[16] = '{0, 0, 0, 8'd56, 14'h0000, 0, 16'h7FFF, 1, 0};
    tv[17] = '{0, 0, 0, 8'hC8, 14'h0000, 0, 16'h0001, 1, 0};
    tv[18] = '{1, 0, 0, 8'hFF, 14'h0000, 0, 16'hC800, 0, 0};
    tv[19] = '{0, 0, 0, 8'hFB, 14'h0000, 0, 16'h1C00, 0, 0};
    tv[20] = '{0, 0, 0, 8'h00, 14'b00000000000100, 1, 16'h4001, 0, 1};
    tv[21] = '{0, 0, 0, 8'h00, 14'b00000000000011, 0, 16'h4000, 0, 1};
    tv[22] = '{1, 0, 0, 8'h08, 14'h0000, 0, 16'h9000, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(tv[0]);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_posit", 32'(out_posit), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 23; i++)
      run_vec(i);

    // Stream with a downstream stall
    ws[0] = 8'h00; we[0] = 16'h4000;
    ws[1] = 8'h04; we[1] = 16'h6000;
    ws[2] = 8'hFF; we[2] = 16'h3800;
    ws[3] = 8'h08; we[3] = 16'h7000;
    sent = 0;
    prev_stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      if (sent < 4) begin
        drive(mkw(ws[sent]));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk($sformatf("stall_hold_c%0d", c), 32'(out_posit), 32'(prev));
        chk($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
      end
      if (c == 3)
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      prev_stall = out_valid && !out_ready;
      prev = out_posit;
      if (out_valid && out_ready)
        rx.push_back(out_posit);
      if (in_valid && in_ready)
        sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(rx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size())
        chk($sformatf("stream_w%0d", i), 32'(rx[i]), 32'(we[i]));
      else
        chk($sformatf("stream_w%0d", i), 32'hDEAD, 32'(we[i]));
    end

    // Reset with two words in flight
    @(negedge clk);
    drive(mkw(8'h04));
    in_valid = 1'b1;
    @(negedge clk);
    drive(mkw(8'h08));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_valid0", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("postrst_valid1", 32'(out_valid), 32'd0);
    drive(mkw(8'hFF));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("postrst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("postrst_lat2", 32'(out_valid), 32'd1);
    chk("postrst_posit", 32'(out_posit), 32'h3800);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
